// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV M-extension multiply/divide, one bit per clock, valid/ready on both sides.
// Optional build macro MULDIV_EARLY_OUT_EN: trivial operations go straight from IDLE to DONE.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2:0]         op_q;
    logic               neg_res_q;
    logic               neg_rem_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [WIDTH-1:0]   result_q;
    logic [2*WIDTH-1:0] prod_q;

    logic             accept;
    logic             is_div;
    logic             sign_a;
    logic             sign_b;
    logic             div_zero;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    assign accept   = in_valid && (state_q == IDLE) && !flush;
    assign is_div   = funct3[2];
    assign sign_a   = rs1[WIDTH-1] && (funct3 != F_MULHU) && (funct3 != F_DIVU) && (funct3 != F_REMU);
    assign sign_b   = rs2[WIDTH-1] && ((funct3 == F_MUL) || (funct3 == F_MULH) ||
                                       (funct3 == F_DIV) || (funct3 == F_REM));
    assign mag_a    = sign_a ? -rs1 : rs1;
    assign mag_b    = sign_b ? -rs2 : rs2;
    assign div_zero = (rs2 == '0);

    logic             early;
    logic [WIDTH-1:0] early_res;
`ifdef MULDIV_EARLY_OUT_EN
    logic overflow;
    assign overflow = ((funct3 == F_DIV) || (funct3 == F_REM)) &&
                      (rs1 == {1'b1, {(WIDTH-1){1'b0}}}) && (rs2 == '1);

    always_comb begin
        early     = 1'b0;
        early_res = '0;
        if (is_div) begin
            // funct3[1] selects the remainder variants
            if (div_zero) begin
                early     = 1'b1;
                early_res = funct3[1] ? rs1 : '1;
            end else if (overflow) begin
                early     = 1'b1;
                early_res = funct3[1] ? '0 : rs1;
            end
        end else if ((rs1 == '0) || (rs2 == '0)) begin
            early = 1'b1;
        end
    end
`else
    assign early     = 1'b0;
    assign early_res = '0;
`endif

    // One datapath step: multiply shifts the multiplier out of the low half while the
    // upper half accumulates; divide shifts dividend bits into the partial remainder.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_tmp;
    logic [WIDTH:0]     div_sub;
    logic [2*WIDTH-1:0] prod_d;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   res_d;

    // NOTE: every signal gets a default at the top of always_comb so no path infers a latch.
    always_comb begin
        mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
        div_tmp = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
        div_sub = div_tmp - {1'b0, opnd_q};
        prod_d  = {mul_sum, prod_q[WIDTH-1:1]};
        if (op_q[2]) begin
            if (div_sub[WIDTH]) prod_d = {div_tmp[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
            else                prod_d = {div_sub[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
        end

        prod_fix = neg_res_q ? -prod_d : prod_d;
        quo      = neg_res_q ? -prod_d[WIDTH-1:0] : prod_d[WIDTH-1:0];
        rem      = neg_rem_q ? -prod_d[2*WIDTH-1:WIDTH] : prod_d[2*WIDTH-1:WIDTH];
        case (op_q)
            F_MUL:                   res_d = prod_fix[WIDTH-1:0];
            F_MULH, F_MULHSU, F_MULHU: res_d = prod_fix[2*WIDTH-1:WIDTH];
            F_DIV, F_DIVU:           res_d = quo;
            default:                 res_d = rem;
        endcase
    end

    // NOTE: the datapath registers are plain flops, so they are reset too; an aborted operation leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            opnd_q    <= '0;
            prod_q    <= '0;
            result_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q      <= funct3;
                        neg_res_q <= (sign_a ^ sign_b) && !(is_div && div_zero);
                        neg_rem_q <= sign_a;
                        cnt_q     <= CNT_W'(WIDTH);
                        opnd_q    <= is_div ? mag_b : mag_a;
                        prod_q    <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
                        if (early) begin
                            result_q <= early_res;
                            state_q  <= DONE;
                        end else begin
                            state_q  <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        state_q <= IDLE;
                    end else begin
                        prod_q <= prod_d;
                        cnt_q  <= cnt_q - CNT_W'(1);
                        // sign fix-up folds into the last iteration
                        if (cnt_q == CNT_W'(1)) begin
                            result_q <= res_d;
                            state_q  <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (flush || out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == CALC) || (state_q == DONE);
    assign result    = result_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised, multi-cycle RV M-extension unit; successor to the combinational ALU, which has no multiply or divide.
- Sits beside the ALU in the execute stage. Accepts one operation per handshake and computes it iteratively, one bit per clock.
- Returns a registered result through a valid/ready output handshake.
- Supports `flush` so a pipeline redirect can abort an operation already in flight.

Parameters:
- WIDTH, 32, operand and result width in bits (any value ≥ 4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request (state IDLE).
- funct3  in  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1  in  WIDTH  operand A (dividend / multiplicand).
- rs2  in  WIDTH  operand B (divisor / multiplier).
- flush  in  1  abort current operation.
- out_valid  out  1  result valid (state DONE).
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  registered result.
- busy  out  1  high in CALC or DONE.

Behaviour:
- **Reset values:**
  - in_ready=1, out_valid=0, busy=0, result=0.
  - FSM=IDLE, counter=0, all datapath registers 0.
  - Reset is asynchronous and overrides everything, including mid-operation; nothing from the aborted operation survives.
- **FSM states:** IDLE, CALC, DONE.
  - IDLE -> CALC on in_valid & in_ready (accept edge T). At T the unit latches funct3, operand signs and the magnitudes |rs1| and |rs2| (signed ops only; MULHSU treats rs2 as unsigned), and loads counter=WIDTH.
  - CALC: one iteration per clock; counter decrements; CALC -> DONE when counter reaches 1.
  - DONE: out_valid=1, result holds stable; DONE -> IDLE on out_ready.
- **Latency:** out_valid first seen high WIDTH+1 clocks after T. Result is held and unchanged under backpressure for any number of cycles.
- **Throughput:** in_ready=0 in CALC and DONE. No new request is accepted until the cycle after the result handshake; back-to-back issue gap is 1 cycle.
- **Multiply:** radix-2 shift-add into a 2×WIDTH product register.
  - MUL returns the low WIDTH bits; MULH/MULHSU/MULHU return the high WIDTH bits.
  - The product is negated in the final step when the operand signs differ.
- **Divide:** restoring shift-subtract producing a WIDTH-bit quotient and remainder.
  - Quotient sign = XOR of operand signs; remainder sign = sign of the dividend.
- **Divide by zero** (rs2=0): quotient = all ones; remainder = rs1.
- **Signed overflow** (rs1 = most negative, rs2 = −1, DIV/REM only): quotient = rs1; remainder = 0.
- **Flush:**
  - In CALC or DONE: go to IDLE next edge, out_valid=0, no result is delivered.
  - Flush beats in_valid in the same cycle: no accept.
  - Flush in IDLE has no effect.
- **out_ready outside DONE** is ignored.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- **Defined:** at accept, the unit detects divide-by-zero, signed overflow, or any multiply with rs1=0 or rs2=0. For these it skips CALC (IDLE -> DONE), so out_valid rises 1 clock after T with the architecturally identical result.
- **Undefined:** every operation takes the full WIDTH+1 latency.
- Result values are identical in both builds; only latency differs.

Test Plan:
- MUL rs1=7, rs2=6 -> result=0x0000002A, out_valid exactly 33 clocks after accept (WIDTH=32, macro off).
- MULH rs1=0xFFFFFFFE (−2), rs2=3 -> 0xFFFFFFFF; MULHU with the same operands -> 0x00000002; MULHSU rs1=−1, rs2=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, with REM = 0x00000000. REM rs1=−7, rs2=2 -> 0xFFFFFFFF; DIVU 100/7 -> 14.
- DIVU 13/0 -> 0xFFFFFFFF and REMU 13/0 -> 13. With MULDIV_EARLY_OUT_EN defined, out_valid arrives 1 clock after accept.
- Hold out_ready=0 for 10 clocks in DONE -> result and out_valid stable, in_ready=0. Then pulse out_ready -> IDLE, in_ready=1 next cycle.
- Assert flush in the 5th CALC cycle with in_valid=1 -> no out_valid, IDLE next edge, next request accepted cleanly. Assert rst_n=0 mid-CALC -> all outputs at reset values immediately, without waiting for a clock edge.
